// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op encoding,
// FSM state type and a reserved-op helper.
package shift_pkg;

   localparam logic [2:0] OP_LSL = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_ASR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // Encodings 101..111 pass the operand through unchanged
   function automatic logic op_rsvd(input logic [2:0] op);
      return op > OP_ROR;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift for every op.
// Ports: op (operation), d (operand), q (operand moved one place).
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_comb begin
      q = d;
      case (op)
         OP_LSL:  q = {d[WIDTH-2:0], 1'b0};
         OP_LSR:  q = {1'b0, d[WIDTH-1:1]};
         OP_ASR:  q = {d[WIDTH-1], d[WIDTH-1:1]};
         OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
         OP_ROR:  q = {d[0], d[WIDTH-1:1]};
         default: q = d;
      endcase
   end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequenced shifter: serial one-place-per-cycle datapath, or a
// single-cycle barrel path when SHIFT_BARREL_EN is defined.
// Ports: clk, reset (sync, active-high), start/op/shamt/d_in
// request, d_out registered result, busy (in SHIFT), done pulse.
module shift_seq_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [2:0]       op_q, op_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic [WIDTH-1:0] step_res;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op (op_q),
      .d  (work_q),
      .q  (step_res)
   );

`ifdef SHIFT_BARREL_EN
   // Stage i moves by 2**i when shamt[i] is set
   function automatic logic [WIDTH-1:0] barrel(
      input logic [2:0]       o,
      input logic [WIDTH-1:0] v,
      input logic [SHW-1:0]   s
   );
      logic [WIDTH-1:0] r;
      int               k;
      r = v;
      for (int i = 0; i < SHW; i++) begin
         k = 1 << i;
         if (s[i]) begin
            case (o)
               OP_LSL:  r = r << k;
               OP_LSR:  r = r >> k;
               OP_ASR:  r = $signed(r) >>> k;
               OP_ROL:  r = (r << k) | (r >> (WIDTH - k));
               OP_ROR:  r = (r >> k) | (r << (WIDTH - k));
               default: r = v;
            endcase
         end
      end
      return r;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      d_out_d = d_out_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               work_d = d_in;
               op_d   = op;
               cnt_d  = shamt;
`ifdef SHIFT_BARREL_EN
               d_out_d = barrel(op, d_in, shamt);
               state_d = ST_DONE;
`else
               // Zero shifts and reserved ops finish at once
               if (shamt == '0 || op_rsvd(op)) begin
                  d_out_d = d_in;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
`endif
            end
         end
         ST_SHIFT: begin
            work_d = step_res;
            cnt_d  = cnt_q - SHW'(1);
            // Last step publishes straight into d_out
            if (cnt_q == SHW'(1)) begin
               d_out_d = step_res;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         d_out_q <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;
   assign busy  = (state_q == ST_SHIFT);
   assign done  = (state_q == ST_DONE);

endmodule
